intctrl: RTL



---
 rtl/intctrl_pkg.sv | 32 +++
 rtl/if_wb.sv | 24 ++
 rtl/prio_enc16.sv | 21 ++
 rtl/intctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/intctrl_pkg.sv
// intctrl_pkg: shared types and constants for the interrupt controller.
//   ctl_state_t  - request/acknowledge/EOI controller states
//   bus_state_t  - Wishbone slave access states
//   REG_*        - register word offsets (adr[5:2])
//   sel_to_mask  - expands a 4-bit byte select into a 32-bit bit mask
package intctrl_pkg;

  localparam int NUM_SRC = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_INSVC = 2'd2
  } ctl_state_t;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_BUSY = 2'd1,
    B_DONE = 2'd2
  } bus_state_t;

  localparam logic [3:0] REG_ENABLE  = 4'd0;
  localparam logic [3:0] REG_MODE    = 4'd1;
  localparam logic [3:0] REG_PENDING = 4'd2;
  localparam logic [3:0] REG_STATUS  = 4'd3;
  localparam logic [3:0] REG_EOI     = 4'd4;

  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/if_wb.sv
// if_wb: 32-bit Wishbone bus bundle shared by the peripherals.
//   cyc, stb, we, sel[3:0], adr[31:0], dat_w[31:0] - driven by the master
//   dat_r[31:0], ack, stall                          - driven by the slave
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, stall
  );
endinterface

// File: rtl/prio_enc16.sv
// prio_enc16: combinational lowest-index priority encoder.
//   req[15:0] in  - request vector
//   valid     out - at least one request set
//   idx[3:0]  out - index of the lowest set request (0 when none)
module prio_enc16 (
  input  logic [15:0] req,
  output logic        valid,
  output logic [3:0]  idx
);

  assign valid = |req;

  // Scan downwards so the lowest set index is the last one to win.
  always_comb begin
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/intctrl.sv
// intctrl: fixed-priority interrupt controller, 16 sources, Wishbone config.
//   clk_i      in  system clock
//   rst_i      in  async active-high reset
//   bus        if  Wishbone slave (adr[5:2] decoded, stall tied 0)
//   src_i      in  interrupt sources, synchronous to clk_i
//   irq_o      out interrupt request to the CPU
//   vec_o      out vector of the requested source
//   irq_ack_i  in  one-cycle CPU acknowledge
//
// Controller FSM
//   state   | meaning
//   S_IDLE  | waiting for an active source; latches lowest index into vec
//   S_REQ   | irq_o high, vec frozen until irq_ack_i
//   S_INSVC | CPU servicing; pending still captured, no request until EOI
//
// Bus FSM
//   state   | meaning
//   B_IDLE  | waiting for cyc & stb
//   B_BUSY  | register read/write performed on the closing edge
//   B_DONE  | ack high, registered read data valid
module intctrl
  import intctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  if_wb.slave                bus,
  input  logic [NUM_SRC-1:0] src_i,
  output logic               irq_o,
  output logic [3:0]         vec_o,
  input  logic               irq_ack_i
);

  bus_state_t bus_state, bus_state_d;
  ctl_state_t ctl_state, ctl_state_d;

  logic [NUM_SRC-1:0] enable_q;
  logic               gen_q;
  logic [NUM_SRC-1:0] mode_q;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [3:0]         vec_q, vec_d;
  logic [31:0]        dat_r_q;
  logic [31:0]        rd_data;

  logic [3:0]         reg_adr;
  logic [31:0]        wmask;
  logic               access;
  logic               wr_en;
  logic               eoi_wr;
  logic               ack_clr;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pend_wr_clr;
  logic [NUM_SRC-1:0] ack_clr_mask;
  logic [NUM_SRC-1:0] active;
  logic               active_valid;
  logic [3:0]         active_idx;

  assign reg_adr = bus.adr[5:2];
  assign wmask   = sel_to_mask(bus.sel);
  assign access  = (bus_state == B_BUSY);
  assign wr_en   = access && bus.we;
  assign eoi_wr  = wr_en && (reg_adr == REG_EOI);

  // Address and data bits outside the decoded window are not used.
  logic unused_bits;
  assign unused_bits = ^{bus.adr[31:6], bus.adr[1:0], bus.dat_w[30:16], wmask[30:16]};

  // ---------------- bus FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bus_state <= B_IDLE;
    else       bus_state <= bus_state_d;
  end

  always_comb begin
    bus_state_d = bus_state;
    case (bus_state)
      B_IDLE:  if (bus.cyc && bus.stb) bus_state_d = B_BUSY;
      B_BUSY:  bus_state_d = B_DONE;
      B_DONE:  bus_state_d = B_IDLE;
      default: bus_state_d = B_IDLE;
    endcase
  end

  assign bus.ack   = (bus_state == B_DONE);
  assign bus.stall = 1'b0;
  assign bus.dat_r = dat_r_q;

  always_comb begin
    rd_data = 32'd0;
    case (reg_adr)
      REG_ENABLE:  rd_data = {gen_q, 15'd0, enable_q};
      REG_MODE:    rd_data = {16'd0, mode_q};
      REG_PENDING: rd_data = {16'd0, pending_q};
      REG_STATUS:  rd_data = {ctl_state, 26'd0, vec_q};
      default:     rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enable_q <= '0;
      gen_q    <= 1'b0;
      mode_q   <= '0;
      dat_r_q  <= 32'd0;
    end else begin
      if (access) dat_r_q <= rd_data;
      if (wr_en && (reg_adr == REG_ENABLE)) begin
        enable_q <= (enable_q & ~wmask[15:0]) | (bus.dat_w[15:0] & wmask[15:0]);
        if (wmask[31]) gen_q <= bus.dat_w[31];
      end
      if (wr_en && (reg_adr == REG_MODE)) begin
        mode_q <= (mode_q & ~wmask[15:0]) | (bus.dat_w[15:0] & wmask[15:0]);
      end
    end
  end

  // ---------------- capture ----------------
  assign rise         = src_i & ~prev_q;
  assign pend_wr_clr  = (wr_en && (reg_adr == REG_PENDING)) ? (bus.dat_w[15:0] & wmask[15:0]) : '0;
  assign ack_clr_mask = ack_clr ? (16'd1 << vec_q) : '0;

  // Edge bits: a rise in the same cycle as a clear keeps the bit set.
  // Level bits simply follow the registered source.
  assign pending_d = (mode_q & (rise | (pending_q & ~(pend_wr_clr | ack_clr_mask))))
                   | (~mode_q & src_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= src_i;
      pending_q <= pending_d;
    end
  end

  assign active = pending_q & enable_q & {NUM_SRC{gen_q}};

  prio_enc16 u_prio (
    .req   (active),
    .valid (active_valid),
    .idx   (active_idx)
  );

  // ---------------- controller FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctl_state <= S_IDLE;
      vec_q     <= 4'd0;
    end else begin
      ctl_state <= ctl_state_d;
      vec_q     <= vec_d;
    end
  end

  always_comb begin
    ctl_state_d = ctl_state;
    vec_d       = vec_q;
    ack_clr     = 1'b0;
    case (ctl_state)
      S_IDLE: begin
        if (active_valid) begin
          vec_d       = active_idx;
          ctl_state_d = S_REQ;
        end
      end
      S_REQ: begin
        // The request is not withdrawn if the source drops or is masked.
        if (irq_ack_i) begin
          ack_clr     = 1'b1;
          ctl_state_d = S_INSVC;
        end
      end
      S_INSVC: begin
        if (eoi_wr) ctl_state_d = S_IDLE;
      end
      default: ctl_state_d = S_IDLE;
    endcase
  end

  assign irq_o = (ctl_state == S_REQ);
  assign vec_o = vec_q;

endmodule
